// File: rtl/pkg_alu.sv
// Shared opcode definitions for the vector add/logic unit.
package pkg_alu;

    localparam int unsigned OpcodeWidth = 4;

    typedef enum logic [OpcodeWidth-1:0] {
        OpAdd  = 4'h0,
        OpSub  = 4'h1,
        OpAnd  = 4'h2,
        OpOr   = 4'h3,
        OpXor  = 4'h4,
        OpNota = 4'h5,
        OpAcc  = 4'h6
    } opcode_alv_t;

endpackage

// File: rtl/add_logic_lane.sv
// One SIMD lane: wrapping or saturating add/sub and bitwise logic, purely combinational.
module add_logic_lane
    import pkg_alu::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  opcode_alv_t      op_i,
    input  logic             sat_i,
    input  logic             signed_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    localparam logic [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           add_ovf;
    logic           sub_ovf;

    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign diff    = {1'b0, a_i} - {1'b0, b_i};
    assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

    // Signed overflow always saturates toward the sign of A.
    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        case (op_i)
            OpAdd: begin
                carry_o = signed_i ? add_ovf : sum[WIDTH];
                res_o   = sum[WIDTH-1:0];
                if (sat_i && carry_o) begin
                    res_o = signed_i ? (a_i[WIDTH-1] ? SMin : SMax) : '1;
                end
            end
            OpSub: begin
                carry_o = signed_i ? sub_ovf : diff[WIDTH];
                res_o   = diff[WIDTH-1:0];
                if (sat_i && carry_o) begin
                    res_o = signed_i ? (a_i[WIDTH-1] ? SMin : SMax) : '0;
                end
            end
            OpAnd:   res_o = a_i & b_i;
            OpOr:    res_o = a_i | b_i;
            OpXor:   res_o = a_i ^ b_i;
            OpNota:  res_o = ~a_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/add_logic_vec.sv
// SIMD add/logic unit with two-source join, stallable DEPTH-stage pipeline and
// a cross-lane accumulator for streamed reductions.
module add_logic_vec
    import pkg_alu::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     I_Active,
    input  logic [OpcodeWidth-1:0]   I_Opcode,
    input  logic                     I_Sat,
    input  logic                     I_Signed,
    input  logic                     I_EnSrcA,
    input  logic                     I_EnSrcB,
    input  logic                     I_Valid_A,
    input  logic                     I_Valid_B,
    input  logic [LANES*WIDTH-1:0]   I_Data_A,
    input  logic [LANES*WIDTH-1:0]   I_Data_B,
    input  logic                     I_Last_A,
    output logic                     O_Nack_A,
    output logic                     O_Nack_B,
    output logic                     O_Valid,
    output logic [LANES*WIDTH-1:0]   O_Data,
    output logic [LANES-1:0]         O_Carry,
    output logic                     O_Last,
    input  logic                     I_Nack
);

    localparam int unsigned VecW = LANES * WIDTH;

    opcode_alv_t       op;
    logic              stall;
    logic              fire;
    logic              is_acc;
    logic [VecW-1:0]   opnd_a;
    logic [VecW-1:0]   opnd_b;
    logic [VecW-1:0]   lane_res;
    logic [LANES-1:0]  lane_carry;

    logic [WIDTH-1:0]  acc_chain [LANES+1];
    logic [LANES-1:0]  acc_ovf;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic              acc_sticky;

    logic              tok_vld;
    logic [VecW-1:0]   tok_data;
    logic [LANES-1:0]  tok_carry;
    logic              tok_last;

    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  last_q;
    logic [VecW-1:0]   data_q  [DEPTH];
    logic [LANES-1:0]  carry_q [DEPTH];

    assign op     = opcode_alv_t'(I_Opcode);
    assign is_acc = (op == OpAcc);
    assign stall  = O_Valid & I_Nack;
    assign fire   = I_Active & ~stall & (~I_EnSrcA | I_Valid_A) & (~I_EnSrcB | I_Valid_B)
                  & (I_EnSrcA | I_EnSrcB);

    assign O_Nack_A = ~reset & I_EnSrcA & I_Valid_A & ~fire;
    assign O_Nack_B = ~reset & I_EnSrcB & I_Valid_B & ~fire;

    assign opnd_a = I_EnSrcA ? I_Data_A : '0;
    assign opnd_b = I_EnSrcB ? I_Data_B : '0;

    // Second lane row chains the accumulator through every lane of A, one saturating add each.
    assign acc_chain[0] = acc_q;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        add_logic_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .a_i      (opnd_a[i*WIDTH +: WIDTH]),
            .b_i      (opnd_b[i*WIDTH +: WIDTH]),
            .op_i     (op),
            .sat_i    (I_Sat),
            .signed_i (I_Signed),
            .res_o    (lane_res[i*WIDTH +: WIDTH]),
            .carry_o  (lane_carry[i])
        );

        add_logic_lane #(
            .WIDTH (WIDTH)
        ) u_acc (
            .a_i      (acc_chain[i]),
            .b_i      (opnd_a[i*WIDTH +: WIDTH]),
            .op_i     (OpAdd),
            .sat_i    (I_Sat),
            .signed_i (I_Signed),
            .res_o    (acc_chain[i+1]),
            .carry_o  (acc_ovf[i])
        );
    end

    assign acc_sticky = sticky_q | (|acc_ovf);

    always_comb begin
        tok_vld   = fire & (~is_acc | I_Last_A);
        tok_data  = '0;
        tok_carry = '0;
        tok_last  = 1'b0;
        if (tok_vld) begin
            if (is_acc) begin
                tok_data[WIDTH-1:0] = acc_chain[LANES];
                tok_carry[0]        = acc_sticky;
                tok_last            = 1'b1;
            end else begin
                tok_data  = lane_res;
                tok_carry = lane_carry;
                tok_last  = I_Last_A;
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        sticky_d = sticky_q;
        if (!I_Active || (fire && is_acc && I_Last_A)) begin
            acc_d    = '0;
            sticky_d = 1'b0;
        end else if (fire && is_acc) begin
            acc_d    = acc_chain[LANES];
            sticky_d = acc_sticky;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                carry_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0]   <= tok_vld;
            last_q[0]  <= tok_last;
            data_q[0]  <= tok_data;
            carry_q[0] <= tok_carry;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i]   <= vld_q[i-1];
                last_q[i]  <= last_q[i-1];
                data_q[i]  <= data_q[i-1];
                carry_q[i] <= carry_q[i-1];
            end
        end
    end

    assign O_Valid = vld_q[DEPTH-1];
    assign O_Last  = last_q[DEPTH-1];
    assign O_Data  = data_q[DEPTH-1];
    assign O_Carry = carry_q[DEPTH-1];

endmodule

// File: tb/tb_add_logic_vec.sv
// Bench for add_logic_vec at WIDTH=8, LANES=4, DEPTH=2: vector table plus scoreboarded sequences.
module tb_add_logic_vec;
    import pkg_alu::*;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned VW = W * L;

    logic          clock = 1'b0;
    logic          reset;
    logic          I_Active, I_Sat, I_Signed, I_EnSrcA, I_EnSrcB;
    logic          I_Valid_A, I_Valid_B, I_Last_A, I_Nack;
    logic [3:0]    I_Opcode;
    logic [VW-1:0] I_Data_A, I_Data_B;
    logic          O_Nack_A, O_Nack_B, O_Valid, O_Last;
    logic [VW-1:0] O_Data;
    logic [L-1:0]  O_Carry;

    add_logic_vec #(
        .WIDTH (W),
        .LANES (L),
        .DEPTH (D)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Active  (I_Active),
        .I_Opcode  (I_Opcode),
        .I_Sat     (I_Sat),
        .I_Signed  (I_Signed),
        .I_EnSrcA  (I_EnSrcA),
        .I_EnSrcB  (I_EnSrcB),
        .I_Valid_A (I_Valid_A),
        .I_Valid_B (I_Valid_B),
        .I_Data_A  (I_Data_A),
        .I_Data_B  (I_Data_B),
        .I_Last_A  (I_Last_A),
        .O_Nack_A  (O_Nack_A),
        .O_Nack_B  (O_Nack_B),
        .O_Valid   (O_Valid),
        .O_Data    (O_Data),
        .O_Carry   (O_Carry),
        .O_Last    (O_Last),
        .I_Nack    (I_Nack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]    op;
        logic          sat;
        logic          sgn;
        logic          last;
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [VW-1:0] exp_data;
        logic [L-1:0]  exp_carry;
    } vec_t;

    typedef struct {
        logic [VW-1:0] data;
        logic [L-1:0]  carry;
        logic          last;
        int            fire_cyc;
    } exp_t;

    vec_t vt [12];
    exp_t sb [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    bit   lat_check = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Each accepted output token is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (!reset && O_Valid && !I_Nack) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_token: got data %h, required no token", O_Data);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", O_Data, mon_e.data);
                check("out_carry", O_Carry, mon_e.carry);
                check("out_last", O_Last, mon_e.last);
                if (lat_check) check("latency", cyc - mon_e.fire_cyc, D);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic sat, input logic sgn,
                        input logic ena, input logic enb, input logic last,
                        input logic [VW-1:0] a, input logic [VW-1:0] b, input bit push,
                        input logic [VW-1:0] ed, input logic [L-1:0] ec, input logic el);
        int   w = 0;
        exp_t e;
        I_Active  = 1'b1;
        I_Opcode  = op;
        I_Sat     = sat;
        I_Signed  = sgn;
        I_EnSrcA  = ena;
        I_EnSrcB  = enb;
        I_Valid_A = 1'b1;
        I_Valid_B = 1'b1;
        I_Data_A  = a;
        I_Data_B  = b;
        I_Last_A  = last;
        @(negedge clock);
        while ((ena ? O_Nack_A : O_Nack_B) && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (w >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got nack for 50 cycles, required fire");
        end else if (push) begin
            e.data     = ed;
            e.carry    = ec;
            e.last     = el;
            e.fire_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        I_Valid_A = 1'b0;
        I_Valid_B = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clock);
            w++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        int outs0;
        logic [VW-1:0] held;

        // op, sat, sgn, last, A (lane3..lane0), B, expected data, expected carry
        vt[0]  = '{OpAdd,  1'b0, 1'b0, 1'b0, 32'h7F1001FF, 32'h01010101, 32'h80110200, 4'b0001};
        vt[1]  = '{OpAdd,  1'b1, 1'b1, 1'b0, 32'hF010807F, 32'h0101FF01, 32'hF111807F, 4'b0011};
        vt[2]  = '{OpSub,  1'b1, 1'b0, 1'b0, 32'h00FF0905, 32'h01010509, 32'h00FE0400, 4'b1001};
        vt[3]  = '{OpSub,  1'b0, 1'b0, 1'b0, 32'h00FF0905, 32'h01010509, 32'hFFFE04FC, 4'b1001};
        vt[4]  = '{OpSub,  1'b0, 1'b1, 1'b0, 32'h05107F80, 32'h0320FF01, 32'h02F0807F, 4'b0011};
        vt[5]  = '{OpSub,  1'b1, 1'b1, 1'b0, 32'h05107F80, 32'h0320FF01, 32'h02F07F80, 4'b0011};
        vt[6]  = '{OpAdd,  1'b1, 1'b0, 1'b0, 32'h1080F0FF, 32'h01807F01, 32'h11FFFFFF, 4'b0111};
        vt[7]  = '{OpAnd,  1'b1, 1'b1, 1'b0, 32'hF0F0AA55, 32'hFF0F0F0F, 32'hF0000A05, 4'b0000};
        vt[8]  = '{OpOr,   1'b0, 1'b0, 1'b1, 32'hF0F0AA55, 32'hFF0F0F0F, 32'hFFFFAF5F, 4'b0000};
        vt[9]  = '{OpXor,  1'b0, 1'b0, 1'b0, 32'hF0F0AA55, 32'hFF0F0F0F, 32'h0FFFA55A, 4'b0000};
        vt[10] = '{OpNota, 1'b0, 1'b1, 1'b0, 32'hF0F0AA55, 32'hFF0F0F0F, 32'h0F0F55AA, 4'b0000};
        vt[11] = '{4'hF,   1'b1, 1'b0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0000};

        reset     = 1'b1;
        I_Active  = 1'b1;
        I_Opcode  = 4'(OpAdd);
        I_Sat     = 1'b0;
        I_Signed  = 1'b0;
        I_EnSrcA  = 1'b1;
        I_EnSrcB  = 1'b1;
        I_Valid_A = 1'b1;
        I_Valid_B = 1'b0;
        I_Data_A  = '0;
        I_Data_B  = '0;
        I_Last_A  = 1'b0;
        I_Nack    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", O_Valid, 0);
        check("rst_data", O_Data, 0);
        check("rst_carry", O_Carry, 0);
        check("rst_last", O_Last, 0);
        check("rst_nack_a", O_Nack_A, 0);
        check("rst_nack_b", O_Nack_B, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        I_Valid_A = 1'b0;

        lat_check = 1'b1;
        foreach (vt[i]) begin
            send(vt[i].op, vt[i].sat, vt[i].sgn, 1'b1, 1'b1, vt[i].last, vt[i].a, vt[i].b,
                 1'b1, vt[i].exp_data, vt[i].exp_carry, vt[i].last);
            @(posedge clock);
            #1;
        end
        drain();

        // Disabled A: operand reads as zero, so 0 - 1 borrows in every lane.
        send(OpSub, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h01010101, 1'b1,
             32'hFFFFFFFF, 4'b1111, 1'b0);
        drain();
        lat_check = 1'b0;

        // Back-to-back stream with a three-cycle downstream stall while the pipe is full.
        outs0 = n_out;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(OpAdd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {4{8'(k * 16)}}, 32'h01010101,
                         1'b1, {4{8'(k * 16 + 1)}}, 4'b0000, 1'b0);
                end
            end
            begin
                int w = 0;
                while (!O_Valid && w < 50) begin
                    @(negedge clock);
                    w++;
                end
                check("stall_first_out", O_Valid, 1);
                @(posedge clock);
                #1;
                I_Nack = 1'b1;
                @(negedge clock);
                held = O_Data;
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clock);
                    check("stall_valid", O_Valid, 1);
                    check("stall_data", O_Data, held);
                    check("stall_nack_a", O_Nack_A, 1);
                end
                @(posedge clock);
                #1;
                I_Nack = 1'b0;
            end
        join
        drain();
        check("stream_count", n_out - outs0, 6);

        // Accumulation: overflow streams, then a clean stream proving the sticky flag cleared.
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40404040, '0, 1'b1,
             32'h00000000, 4'b0001, 1'b1);
        send(OpAcc, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40404040, '0, 1'b0, '0, '0, 1'b0);
        send(OpAcc, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, '0, 1'b1,
             32'h000000FF, 4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, (k == 2), 32'h01010101, 32'hFFFFFFFF, (k == 2),
                 32'h0000000C, 4'b0000, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, (k == 1), 32'h02020202, '0, (k == 1),
                 32'h00000010, 4'b0000, 1'b0 | (k == 1));
        end
        drain();

        // Join: both sources enabled but only A valid must nack A and produce nothing.
        outs0     = n_out;
        I_Opcode  = 4'(OpAdd);
        I_EnSrcA  = 1'b1;
        I_EnSrcB  = 1'b1;
        I_Valid_A = 1'b1;
        I_Valid_B = 1'b0;
        I_Data_A  = 32'h04030201;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("join_nack_a", O_Nack_A, 1);
            check("join_nack_b", O_Nack_B, 0);
        end
        check("join_no_out", n_out - outs0, 0);
        @(posedge clock);
        #1;
        send(OpAdd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04030201, 32'h11111111, 1'b1,
             32'h04030201, 4'b0000, 1'b0);
        drain();

        // Reset mid-accumulation discards the partial sum.
        outs0 = n_out;
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h05050505, '0, 1'b0, '0, '0, 1'b0);
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h05050505, '0, 1'b0, '0, '0, 1'b0);
        reset     = 1'b1;
        I_EnSrcB  = 1'b1;
        I_Valid_A = 1'b1;
        I_Valid_B = 1'b0;
        @(negedge clock);
        check("midrst_nack_a", O_Nack_A, 0);
        check("midrst_nack_b", O_Nack_B, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        I_Valid_A = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midrst_no_out", n_out - outs0, 0);
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h01010101, '0, 1'b1,
             32'h00000004, 4'b0000, 1'b1);
        drain();

        // Dropping I_Active clears a partial accumulation.
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h03030303, '0, 1'b0, '0, '0, 1'b0);
        I_Active = 1'b0;
        @(posedge clock);
        #1;
        send(OpAcc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h01010101, '0, 1'b1,
             32'h00000004, 4'b0000, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_logic_vec.md
ADD_LOGIC_VEC -- requirements
Module: add_logic_vec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the lane data width in bits (min 4).
REQ-002 SHALL have parameter LANES, default 4, the number of SIMD lanes (min 1).
REQ-003 SHALL have parameter DEPTH, default 2, the pipeline stages from fire to output (min 1).
REQ-004 SHALL have ports: clock  in  1  single clock; reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: I_Active  in  1  enable; I_Opcode  in  4  operation (pkg_alu opcode_alv_t); I_Sat  in  1  saturate; I_Signed  in  1  signed arithmetic.
REQ-006 SHALL have ports: I_EnSrcA / I_EnSrcB  in  1  source used; I_Valid_A / I_Valid_B  in  1  token valid; I_Data_A / I_Data_B  in  LANES*WIDTH  operands; I_Last_A  in  1  end of accumulation stream.
REQ-007 SHALL have ports: O_Nack_A / O_Nack_B  out  1  source must hold; O_Valid  out  1; O_Data  out  LANES*WIDTH; O_Carry  out  LANES  carry/borrow/overflow; O_Last  out  1; I_Nack  in  1  downstream stall.

Function
REQ-008 SHALL define stall = O_Valid & I_Nack, and fire = I_Active & ~stall & (~I_EnSrcA | I_Valid_A) & (~I_EnSrcB | I_Valid_B) & (I_EnSrcA | I_EnSrcB).
REQ-009 SHALL treat a disabled source's operand as zero and SHALL hold O_Nack of a disabled source at 0.
REQ-010 SHALL assert O_Nack_X when I_EnSrcX & I_Valid_X & ~fire; a nacked source holds its token unchanged.
REQ-011 SHALL implement opcodes ADD, SUB, AND, OR, XOR, NOTA, ACC; any other code SHALL produce zero data with O_Valid following fire.
REQ-012 SHALL present the fire result on O_Data/O_Valid exactly DEPTH cycles after fire when no stall occurs.
REQ-013 SHALL freeze all pipeline stages, including O_Data, O_Carry, O_Last and O_Valid, on every cycle stall is high; no token is lost or duplicated.
REQ-014 SHALL propagate bubbles: a stage without a token holds valid 0.
REQ-015 ADD/SUB SHALL be computed per lane modulo 2^WIDTH when I_Sat=0; O_Carry[i] = unsigned carry-out (ADD) or borrow (SUB) when I_Signed=0, and signed overflow when I_Signed=1.
REQ-016 When I_Sat=1, ADD/SUB SHALL clamp: unsigned to all-ones on carry and to 0 on borrow; signed to 2^(WIDTH-1)-1 on positive overflow and -2^(WIDTH-1) on negative overflow; O_Carry still flags the event.
REQ-017 Logic opcodes SHALL act bitwise per lane, with O_Carry = 0; NOTA ignores B.
REQ-018 ACC SHALL add the sum of all lanes of A into a WIDTH-bit accumulator on each fire, applying the I_Sat/I_Signed rules of REQ-015/016 to every addition.
REQ-019 ACC SHALL produce no output token for a fire with I_Last_A=0; for a fire with I_Last_A=1 it SHALL output lane0 = final sum, other lanes = 0, O_Last = 1, O_Carry[0] = sticky overflow of the stream, then clear the accumulator and the sticky flag in the same cycle.
REQ-020 SHALL clear the accumulator and the sticky flag when I_Active=0; tokens already in the pipeline still drain.
REQ-021 O_Last SHALL equal I_Last_A of the fire for non-ACC opcodes.
REQ-022 Opcode, I_Sat and I_Signed SHALL be sampled at fire and carried with the token.

Reset
REQ-023 reset SHALL clear all stage valids, data, carries and last flags, the accumulator and the sticky flag, so that O_Valid=0, O_Data=0, O_Carry=0 and O_Last=0.
REQ-024 SHALL hold O_Nack_A=O_Nack_B=0 while reset is high.
REQ-025 A reset mid-accumulation SHALL discard the partial sum and produce no output.

Structure
REQ-026 opcode_alv_t and its encodings SHALL reside in pkg_alu.
REQ-027 Per-lane arithmetic/logic SHALL be a combinational sub-module add_logic_lane, instantiated LANES times; the pipeline, the join and the accumulator SHALL live in add_logic_vec.

Verification (WIDTH=8, LANES=4, DEPTH=2)
REQ-028 ADD, I_Sat=0, I_Signed=0, A=FF,01,10,7F, B=01 in every lane -> 2 cycles later O_Data=00,02,11,80, O_Carry=0001b (lane0).
REQ-029 ADD, I_Sat=1, I_Signed=1, A=7F,80, B=01,FF -> 7F,80 with O_Carry set on both lanes; SUB, I_Sat=1, I_Signed=0, 05-09 -> 00, carry=1.
REQ-030 Streaming 6 tokens with I_Nack high for 3 cycles while the pipe is full -> O_Data stable, O_Nack_A=1 during the stall, 6 outputs in order.
REQ-031 ACC, 3 beats with all A lanes=01, I_Last_A on beat 3 -> one token, lane0=0C, O_Last=1; a following stream starts from 0.
REQ-032 Both sources enabled, only A valid -> O_Nack_A=1, no output; set I_EnSrcB=0 -> fire with B=0; reset after 2 ACC beats -> no output, accumulator 0.
